async_mutex_client: RTL and testbench
=====================================

Name: async_mutex_client

Overview:
- Synchronous requester-side front end for the two-input asynchronous mutex used in the CMP lock hardware. One instance per contending clock domain.
- Converts core-side acquire/release command pulses into the mutex's level-sensitive four-phase request.
- Synchronises the asynchronous grant back into the local clock domain, acknowledges the core, and records how long each acquire waited.

Parameters:
- SYNC_STAGES, 2, number of flip-flops in the grant synchroniser; legal range 2..4.
- WAIT_W, 16, width of the acquire-wait cycle counter.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- acq_i  in  1  single-cycle acquire command from core.
- rel_i  in  1  single-cycle release command from core.
- ack_o  out  1  one-cycle pulse: acquire granted, or release completed.
- err_o  out  1  one-cycle pulse: command illegal in the current state.
- held_o  out  1  level; lock currently owned by this client.
- busy_o  out  1  level; a transaction is in flight (states REQ, REL).
- wait_o  out  WAIT_W  cycles the last acquire spent in REQ.
- mutex_req_o  out  1  to mutex request input; registered, glitch-free.
- mutex_grant_i  in  1  from mutex grant output; asynchronous to clk.

Behaviour:
- Reset values: all outputs 0.
  - mutex_req_o drops to 0 asynchronously on reset.
  - The FSM enters REL, not IDLE. This drains any grant still asserted by the mutex.
- Synchroniser: g_s is mutex_grant_i after SYNC_STAGES flops. All synchroniser flops reset to 0.
- FSM states and transitions:
  - IDLE → REQ on acq_i. mutex_req_o = 1 from the next cycle.
  - REQ → HELD when g_s = 1. In that same transition:
    - held_o = 1 and ack_o pulses, both registered and visible the cycle after g_s is first seen high.
    - wait_o latches the counter value.
  - HELD → REL on rel_i. mutex_req_o = 0 from the next cycle; held_o = 0 on the same edge.
  - REL → IDLE when g_s = 0. ack_o pulses on the same edge, unless REL was entered from reset; then there is no ack.
- Illegal commands (err_o pulses the next cycle, state unchanged):
  - rel_i in IDLE, REQ or REL.
  - acq_i in REQ, HELD or REL.
  - acq_i and rel_i together in any state. Both are treated as illegal; neither is executed.
- Four-phase rule: mutex_req_o never rises while g_s = 1 and never falls while in REQ. Consequently, an acquire cannot be abandoned once issued.
- Wait counter:
  - Cleared on IDLE→REQ.
  - Increments once per cycle while in REQ.
  - Saturates at 2^WAIT_W - 1 with no wrap.
  - wait_o holds its value until the next HELD entry.
- Minimum latencies:
  - acq_i → ack_o = SYNC_STAGES + 2 cycles when uncontended (default 4).
  - rel_i → ack_o = SYNC_STAGES + 2 cycles.
- busy_o = 1 exactly in REQ and REL, including the post-reset REL drain.
- Reset mid-operation: every state returns to REL at once, with mutex_req_o = 0. No ack is issued for the aborted transaction.
- No combinational path from any input to any output.

Decomposition:
- Shared package (async_mutex_pkg):
  - FSM state enum: IDLE, REQ, HELD, REL.
  - SYNC_STAGES default and legal-range constants.
- One sub-module: bit_synchronizer (parameter STAGES, ports clk, reset, d, q; reset-to-0 flop chain). It is reused by other async-crossing blocks.

Test Plan:
- Post-reset drain: hold mutex_grant_i = 1 through reset release, drop it at cycle 10 → busy_o = 1 until g_s falls; IDLE at cycle 10 + SYNC_STAGES; no ack_o; acq_i before then gives err_o.
- Uncontended acquire/release: acq_i at cycle 0, model grants one cycle after mutex_req_o rises → ack_o at cycle 4, held_o = 1, wait_o = 3; rel_i at cycle 10 → mutex_req_o = 0 at 11, ack_o at 14, held_o = 0 at 11.
- Contention with two clients on a real AsyncMutex2 instance: other side holds for 50 cycles → this client's wait_o ≥ 50; held_o is never 1 on both clients simultaneously.
- Saturation: WAIT_W = 4, grant withheld for 40 cycles → wait_o = 15.
- Illegal commands:
  - rel_i in IDLE → err_o.
  - acq_i in HELD → err_o.
  - acq_i and rel_i together in HELD → err_o, still HELD.
  - No state or port change in any of the three cases.
- Reset in HELD: assert reset for 1 cycle → mutex_req_o = 0 immediately, held_o = 0; REL until model grant low, then IDLE with no ack.

Source files
------------

// File: rtl/async_mutex_pkg.sv
// Shared types and constants for the asynchronous-mutex requester front end.
// Contents: FSM state encoding, synchroniser depth default and legal range,
// default width of the acquire-wait counter.
package async_mutex_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HELD = 2'd2,
    REL  = 2'd3
  } mutex_state_e;

  localparam int unsigned SYNC_STAGES_DEF = 2;
  localparam int unsigned SYNC_STAGES_MIN = 2;
  localparam int unsigned SYNC_STAGES_MAX = 4;

  localparam int unsigned WAIT_W_DEF = 16;

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchroniser for a single asynchronous level.
// Ports:
//   clk   - destination clock
//   reset - asynchronous active-high reset, clears every stage to 0
//   d     - asynchronous input level
//   q     - synchronised level, STAGES clk edges behind d
module bit_synchronizer #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  // Plain shift chain; stage 0 is the metastability-exposed flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/async_mutex_client.sv
// Requester-side front end for a two-input asynchronous mutex.
// Turns acquire/release command pulses into a four-phase mutex request,
// synchronises the grant, acknowledges the core and records acquire wait time.
// Ports:
//   clk, reset     - clock, asynchronous active-high reset
//   acq_i, rel_i   - single-cycle acquire / release commands
//   ack_o          - pulse: acquire granted or release completed
//   err_o          - pulse: command illegal in the current state
//   held_o         - level: lock owned by this client
//   busy_o         - level: acquire or release in flight
//   wait_o         - cycles the last acquire spent waiting (saturating)
//   mutex_req_o    - registered request to the mutex
//   mutex_grant_i  - grant from the mutex, asynchronous to clk
// SYNC_STAGES must lie in SYNC_STAGES_MIN..SYNC_STAGES_MAX.
module async_mutex_client
  import async_mutex_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int unsigned WAIT_W      = WAIT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              acq_i,
  input  logic              rel_i,
  output logic              ack_o,
  output logic              err_o,
  output logic              held_o,
  output logic              busy_o,
  output logic [WAIT_W-1:0] wait_o,
  output logic              mutex_req_o,
  input  logic              mutex_grant_i
);

  localparam int unsigned       SETTLE_W = $clog2(SYNC_STAGES + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = {WAIT_W{1'b1}};

  mutex_state_e        state_q, state_d;
  logic                drain_q, drain_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic                settle_done;
  logic                g_s;
  logic                cmd_err;

  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d, wait_inc;
  logic                ack_d, err_d, held_d, busy_d, req_d;
  logic [WAIT_W-1:0]   wait_d;

  // Grant crossing into the local clock domain.
  bit_synchronizer #(
    .STAGES (SYNC_STAGES)
  ) u_grant_sync (
    .clk   (clk),
    .reset (reset),
    .d     (mutex_grant_i),
    .q     (g_s)
  );

  // The synchroniser restarts at 0 after reset, so g_s says nothing about the
  // real grant until it has been refilled; the reset drain waits for that.
  assign settle_done = (settle_q == SETTLE_W'(SYNC_STAGES));

  // State register; reset lands in REL to drain a grant left over by the mutex.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= REL;
      drain_q  <= 1'b1;
      settle_q <= '0;
    end else begin
      state_q  <= state_d;
      drain_q  <= drain_d;
      settle_q <= settle_d;
    end
  end

  // Next-state logic and command legality.
  always_comb begin
    state_d  = state_q;
    cmd_err  = 1'b0;
    drain_d  = drain_q;
    settle_d = settle_done ? settle_q : settle_q + SETTLE_W'(1);
    if (acq_i && rel_i) begin
      cmd_err = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (rel_i) begin
            cmd_err = 1'b1;
          end else if (acq_i) begin
            // A raised request must never meet a grant that is still high.
            if (g_s) cmd_err = 1'b1;
            else     state_d = REQ;
          end
        end
        REQ: begin
          if (acq_i || rel_i) cmd_err = 1'b1;
          else if (g_s)       state_d = HELD;
        end
        HELD: begin
          if (acq_i)      cmd_err = 1'b1;
          else if (rel_i) state_d = REL;
        end
        REL: begin
          if (acq_i || rel_i) begin
            cmd_err = 1'b1;
          end else if (!g_s && settle_done) begin
            state_d = IDLE;
            drain_d = 1'b0;
          end
        end
        default: state_d = REL;
      endcase
    end
  end

  // Next output values, all taken from the upcoming state so they register.
  always_comb begin
    wait_inc   = (wait_cnt_q == WAIT_MAX) ? WAIT_MAX : wait_cnt_q + WAIT_W'(1);
    wait_cnt_d = wait_cnt_q;
    wait_d     = wait_o;
    ack_d      = 1'b0;
    err_d      = cmd_err;
    held_d     = (state_d == HELD);
    busy_d     = (state_d == REQ) || (state_d == REL);
    req_d      = (state_d == REQ) || (state_d == HELD);
    if (state_q == IDLE && state_d == REQ) begin
      wait_cnt_d = '0;
    end else if (state_q == REQ) begin
      wait_cnt_d = wait_inc;
    end
    // wait_inc counts the final REQ cycle, so wait_o is cycles spent in REQ.
    if (state_q == REQ && state_d == HELD) begin
      ack_d  = 1'b1;
      wait_d = wait_inc;
    end
    if (state_q == REL && state_d == IDLE && !drain_q) begin
      ack_d = 1'b1;
    end
  end

  // Output and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack_o       <= 1'b0;
      err_o       <= 1'b0;
      held_o      <= 1'b0;
      busy_o      <= 1'b0;
      wait_o      <= '0;
      mutex_req_o <= 1'b0;
      wait_cnt_q  <= '0;
    end else begin
      ack_o       <= ack_d;
      err_o       <= err_d;
      held_o      <= held_d;
      busy_o      <= busy_d;
      wait_o      <= wait_d;
      mutex_req_o <= req_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

endmodule

// File: tb/tb_async_mutex_client.sv
// Bench for async_mutex_client: two clients share a behavioural mutex,
// a third (narrow wait counter) sees a grant the bench withholds at will.
module tb_async_mutex_client;

  localparam int unsigned SYNC = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  logic acq_a = 1'b0, rel_a = 1'b0, ack_a, err_a, held_a, busy_a, req_a, grant_a;
  logic [15:0] wait_a;
  logic acq_b = 1'b0, rel_b = 1'b0, ack_b, err_b, held_b, busy_b, req_b, grant_b;
  logic [15:0] wait_b;
  logic acq_s = 1'b0, rel_s = 1'b0, ack_s, err_s, held_s, busy_s, req_s;
  logic grant_s = 1'b0;
  logic [3:0] wait_s;

  logic hold_grant_a = 1'b0;
  logic gate_s = 1'b0;
  int   owner = 0;
  int   excl_viol = 0;

  async_mutex_client #(.SYNC_STAGES(SYNC), .WAIT_W(16)) dut_a (
    .clk(clk), .reset(reset), .acq_i(acq_a), .rel_i(rel_a), .ack_o(ack_a),
    .err_o(err_a), .held_o(held_a), .busy_o(busy_a), .wait_o(wait_a),
    .mutex_req_o(req_a), .mutex_grant_i(grant_a));

  async_mutex_client #(.SYNC_STAGES(SYNC), .WAIT_W(16)) dut_b (
    .clk(clk), .reset(reset), .acq_i(acq_b), .rel_i(rel_b), .ack_o(ack_b),
    .err_o(err_b), .held_o(held_b), .busy_o(busy_b), .wait_o(wait_b),
    .mutex_req_o(req_b), .mutex_grant_i(grant_b));

  async_mutex_client #(.SYNC_STAGES(SYNC), .WAIT_W(4)) dut_s (
    .clk(clk), .reset(reset), .acq_i(acq_s), .rel_i(rel_s), .ack_o(ack_s),
    .err_o(err_s), .held_o(held_s), .busy_o(busy_s), .wait_o(wait_s),
    .mutex_req_o(req_s), .mutex_grant_i(grant_s));

  initial forever #5 clk = ~clk;

  // Behavioural two-input mutex, evaluated mid-cycle so it is asynchronous to
  // the sampling edge: a dropped request frees it, a pending one takes it.
  always @(negedge clk) begin
    int nxt;
    nxt = owner;
    if (nxt == 1 && !req_a) nxt = 0;
    if (nxt == 2 && !req_b) nxt = 0;
    if (nxt == 0) begin
      if (req_a)      nxt = 1;
      else if (req_b) nxt = 2;
    end
    owner   <= nxt;
    grant_s <= req_s && gate_s;
  end

  assign grant_a = hold_grant_a || (owner == 1);
  assign grant_b = (owner == 2);

  always @(negedge clk) if (held_a && held_b) excl_viol <= excl_viol + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Acquire on client A from IDLE, uncontended; ack and wait are fixed by latency.
  task automatic acquire_a(input string tag);
    acq_a = 1'b1; tick(); acq_a = 1'b0;
    n_checks++; if (req_a !== 1'b1) begin n_fail++; $display("FAIL %s_req_rise: got %b want 1", tag, req_a); end
    for (int j = 2; j <= SYNC + 1; j++) begin
      tick();
      n_checks++; if (ack_a !== 1'b0) begin n_fail++; $display("FAIL %s_ack_early: got %b want 0 at step %0d", tag, ack_a, j); end
    end
    tick();
    n_checks++; if (ack_a !== 1'b1) begin n_fail++; $display("FAIL %s_ack: got %b want 1", tag, ack_a); end
    n_checks++; if (held_a !== 1'b1) begin n_fail++; $display("FAIL %s_held: got %b want 1", tag, held_a); end
    n_checks++; if (wait_a !== 16'(SYNC + 1)) begin n_fail++; $display("FAIL %s_wait: got %0d want %0d", tag, wait_a, SYNC + 1); end
    n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL %s_busy: got %b want 0", tag, busy_a); end
    tick();
    n_checks++; if (ack_a !== 1'b0) begin n_fail++; $display("FAIL %s_ack_pulse: got %b want 0", tag, ack_a); end
  endtask

  task automatic release_a(input string tag);
    rel_a = 1'b1; tick(); rel_a = 1'b0;
    n_checks++; if (req_a !== 1'b0) begin n_fail++; $display("FAIL %s_req_fall: got %b want 0", tag, req_a); end
    n_checks++; if (held_a !== 1'b0) begin n_fail++; $display("FAIL %s_held_fall: got %b want 0", tag, held_a); end
    n_checks++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL %s_rel_busy: got %b want 1", tag, busy_a); end
    for (int j = 2; j <= SYNC + 1; j++) begin
      tick();
      n_checks++; if (ack_a !== 1'b0) begin n_fail++; $display("FAIL %s_rel_ack_early: got %b want 0", tag, ack_a); end
    end
    tick();
    n_checks++; if (ack_a !== 1'b1) begin n_fail++; $display("FAIL %s_rel_ack: got %b want 1", tag, ack_a); end
    n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL %s_rel_idle: got busy %b want 0", tag, busy_a); end
    tick();
  endtask

  task automatic test_reset();
    int k;
    hold_grant_a = 1'b1;
    reset = 1'b1;
    repeat (3) tick();
    n_checks++; if (ack_a !== 1'b0) begin n_fail++; $display("FAIL rst_ack: got %b want 0", ack_a); end
    n_checks++; if (err_a !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", err_a); end
    n_checks++; if (held_a !== 1'b0) begin n_fail++; $display("FAIL rst_held: got %b want 0", held_a); end
    n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy_a); end
    n_checks++; if (wait_a !== 16'd0) begin n_fail++; $display("FAIL rst_wait: got %0d want 0", wait_a); end
    n_checks++; if (req_a !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", req_a); end
    reset = 1'b0;
    k = int'($urandom_range(1, 8));
    // Grant still high: stay in the drain, acquire is rejected.
    for (int i = 1; i <= 10; i++) begin
      acq_a = (i == k);
      tick();
      acq_a = 1'b0;
      n_checks++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL drain_busy: got %b want 1 at %0d", busy_a, i); end
      n_checks++; if (err_a !== (i == k)) begin n_fail++; $display("FAIL drain_err: got %b want %b at %0d", err_a, (i == k), i); end
      n_checks++; if (ack_a !== 1'b0) begin n_fail++; $display("FAIL drain_ack: got %b want 0 at %0d", ack_a, i); end
    end
    hold_grant_a = 1'b0;
    // Grant fall crosses SYNC flops, then the FSM leaves REL on the next edge.
    for (int j = 1; j <= SYNC + 1; j++) begin
      tick();
      n_checks++; if (busy_a !== (j <= SYNC)) begin n_fail++; $display("FAIL drain_exit: busy %b want %b at %0d", busy_a, (j <= SYNC), j); end
      n_checks++; if (ack_a !== 1'b0) begin n_fail++; $display("FAIL drain_noack: got %b want 0 at %0d", ack_a, j); end
    end
    n_checks++; if (busy_b !== 1'b0 || busy_s !== 1'b0) begin n_fail++; $display("FAIL drain_others: busy_b %b busy_s %b want 0", busy_b, busy_s); end
  endtask

  task automatic test_acquire_release();
    for (int it = 0; it < 5; it++) begin
      repeat ($urandom_range(0, 5)) tick();
      acquire_a("ar");
      repeat ($urandom_range(0, 8)) tick();
      n_checks++; if (wait_a !== 16'(SYNC + 1)) begin n_fail++; $display("FAIL ar_wait_hold: got %0d want %0d", wait_a, SYNC + 1); end
      release_a("ar");
    end
  endtask

  task automatic test_illegal();
    // rel in IDLE
    rel_a = 1'b1; tick(); rel_a = 1'b0;
    n_checks++; if (err_a !== 1'b1) begin n_fail++; $display("FAIL ill_idle_err: got %b want 1", err_a); end
    n_checks++; if ({held_a, busy_a, req_a, ack_a} !== 4'b0000) begin n_fail++; $display("FAIL ill_idle_state: got %b want 0000", {held_a, busy_a, req_a, ack_a}); end
    tick();
    n_checks++; if (err_a !== 1'b0) begin n_fail++; $display("FAIL ill_err_pulse: got %b want 0", err_a); end
    acquire_a("ill");
    // acq in HELD, then acq+rel together in HELD
    for (int m = 0; m < 2; m++) begin
      acq_a = 1'b1; rel_a = (m == 1); tick(); acq_a = 1'b0; rel_a = 1'b0;
      n_checks++; if (err_a !== 1'b1) begin n_fail++; $display("FAIL ill_held_err%0d: got %b want 1", m, err_a); end
      n_checks++; if ({held_a, busy_a, req_a, ack_a} !== 4'b1010) begin n_fail++; $display("FAIL ill_held_state%0d: got %b want 1010", m, {held_a, busy_a, req_a, ack_a}); end
      n_checks++; if (wait_a !== 16'(SYNC + 1)) begin n_fail++; $display("FAIL ill_held_wait%0d: got %0d want %0d", m, wait_a, SYNC + 1); end
      tick();
    end
    release_a("ill");
  endtask

  task automatic test_contention();
    int ta, rb, ack_cyc;
    bit seen;
    acq_b = 1'b1; tick(); acq_b = 1'b0;
    repeat ($urandom_range(0, 2)) tick();
    ta = cyc;
    acq_a = 1'b1; tick(); acq_a = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin tick(); seen = held_b; end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL cont_b_held: got 0 want 1 within 20 cycles"); end
    repeat (50 + $urandom_range(0, 10)) tick();
    n_checks++; if (held_a !== 1'b0 || busy_a !== 1'b1) begin n_fail++; $display("FAIL cont_a_waiting: held %b busy %b want 0 1", held_a, busy_a); end
    rb = cyc;
    rel_b = 1'b1; tick(); rel_b = 1'b0;
    seen = 1'b0; ack_cyc = -1;
    for (int i = 0; i < 20 && !seen; i++) begin tick(); seen = ack_a; if (seen) ack_cyc = cyc; end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL cont_a_ack: no ack within 20 cycles of release"); end
    n_checks++; if (ack_cyc != rb + int'(SYNC) + 2) begin n_fail++; $display("FAIL cont_ack_time: got cycle %0d want %0d", ack_cyc, rb + int'(SYNC) + 2); end
    n_checks++; if (int'(wait_a) != rb - ta + int'(SYNC) + 1) begin n_fail++; $display("FAIL cont_wait: got %0d want %0d", wait_a, rb - ta + int'(SYNC) + 1); end
    n_checks++; if (wait_a < 16'd50) begin n_fail++; $display("FAIL cont_wait_min: got %0d want >= 50", wait_a); end
    tick();
    release_a("cont");
    n_checks++; if (busy_b !== 1'b0 || held_b !== 1'b0) begin n_fail++; $display("FAIL cont_b_idle: busy %b held %b want 0 0", busy_b, held_b); end
    n_checks++; if (excl_viol != 0) begin n_fail++; $display("FAIL cont_exclusion: got %0d overlap cycles want 0", excl_viol); end
  endtask

  task automatic test_saturation();
    int w, exp_w;
    bit seen;
    for (int it = 0; it < 3; it++) begin
      w = (it == 0) ? 40 : (it == 1) ? 0 : int'($urandom_range(5, 30));
      exp_w = w + int'(SYNC) + 1;
      if (exp_w > 15) exp_w = 15;
      gate_s = 1'b0;
      acq_s = 1'b1; tick(); acq_s = 1'b0;
      repeat (w) tick();
      gate_s = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin tick(); seen = ack_s; end
      n_checks++; if (!seen) begin n_fail++; $display("FAIL sat_ack%0d: no ack within 10 cycles", it); end
      n_checks++; if (wait_s !== 4'(exp_w)) begin n_fail++; $display("FAIL sat_wait%0d: got %0d want %0d (w=%0d)", it, wait_s, exp_w, w); end
      rel_s = 1'b1; tick(); rel_s = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin tick(); seen = ack_s; end
      n_checks++; if (!seen || busy_s !== 1'b0) begin n_fail++; $display("FAIL sat_rel%0d: ack %b busy %b want 1 0", it, seen, busy_s); end
      tick();
    end
  endtask

  task automatic test_reset_held();
    bit idle, any_ack;
    acquire_a("rh");
    repeat ($urandom_range(1, 6)) tick();
    reset = 1'b1;
    #1;
    n_checks++; if (req_a !== 1'b0) begin n_fail++; $display("FAIL rh_req_async: got %b want 0", req_a); end
    n_checks++; if (held_a !== 1'b0) begin n_fail++; $display("FAIL rh_held_async: got %b want 0", held_a); end
    tick();
    reset = 1'b0;
    idle = 1'b0; any_ack = 1'b0;
    for (int i = 0; i < 12 && !idle; i++) begin
      tick();
      any_ack |= ack_a;
      idle = !busy_a;
    end
    n_checks++; if (!idle) begin n_fail++; $display("FAIL rh_idle: still busy after 12 cycles"); end
    n_checks++; if (any_ack) begin n_fail++; $display("FAIL rh_noack: got ack want none"); end
    n_checks++; if (held_a !== 1'b0 || req_a !== 1'b0) begin n_fail++; $display("FAIL rh_final: held %b req %b want 0 0", held_a, req_a); end
    tick();
    acquire_a("rh2");
    release_a("rh2");
  endtask

  initial begin
    test_reset();
    test_acquire_release();
    test_illegal();
    test_contention();
    test_saturation();
    test_reset_held();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
